dtcm_lsu: RTL

//   Load/store unit: initiator side of the DTCM data port (cs/wr/bwen/addr/data out, 1-cycle registered read data in).

---
 rtl/dtcm_lsu_if.sv | 51 +++++
 rtl/dtcm_lsu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dtcm_lsu_if.sv
// ----------------------------------------------------------------------------
// dtcm_lsu_if
//   Bundles the LSU request/response handshake towards the execute stage and
//   the DTCM data port into one interface.
//   slave  : the LSU's view (takes requests, drives responses and the DTCM
//            select/write/enable/address/data, receives DTCM read data).
//   master : the environment's view (execute stage plus DTCM).
//   Signals:
//     lsu_req_valid/ready/wr/size/unsigned/addr/wdata/rd : load/store request
//     lsu_rsp_valid/rdata/rd/err                          : one-cycle response
//     mem_cs/wr/bwen/addr/data                            : DTCM command
//     mem_data_wb                                         : DTCM read data
// ----------------------------------------------------------------------------
interface dtcm_lsu_if #(
    parameter int AW = 32
);
    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic          lsu_req_wr;
    logic [1:0]    lsu_req_size;
    logic          lsu_req_unsigned;
    logic [AW-1:0] lsu_req_addr;
    logic [31:0]   lsu_req_wdata;
    logic [4:0]    lsu_req_rd;

    logic          lsu_rsp_valid;
    logic [31:0]   lsu_rsp_rdata;
    logic [4:0]    lsu_rsp_rd;
    logic          lsu_rsp_err;

    logic          mem_cs;
    logic          mem_wr;
    logic [3:0]    mem_bwen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic [31:0]   mem_data_wb;

    modport slave (
        input  lsu_req_valid, lsu_req_wr, lsu_req_size, lsu_req_unsigned,
               lsu_req_addr, lsu_req_wdata, lsu_req_rd, mem_data_wb,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_rd,
               lsu_rsp_err, mem_cs, mem_wr, mem_bwen, mem_addr, mem_data
    );

    modport master (
        output lsu_req_valid, lsu_req_wr, lsu_req_size, lsu_req_unsigned,
               lsu_req_addr, lsu_req_wdata, lsu_req_rd, mem_data_wb,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_rd,
               lsu_rsp_err, mem_cs, mem_wr, mem_bwen, mem_addr, mem_data
    );
endinterface

// File: rtl/dtcm_lsu.sv
// ----------------------------------------------------------------------------
// dtcm_lsu
//   Load/store unit between the execute stage and the DTCM data port.
//   A request is taken on valid & ready. Its byte address and size are turned
//   into a word index, byte enables and replicated store data, driven on the
//   DTCM port combinationally in the accept cycle. Stores and faulting
//   requests respond one cycle later; loads wait one cycle for the DTCM read
//   data, align and extend it, and respond two cycles after accept.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : dtcm_lsu_if.slave (request, response and DTCM port)
// ----------------------------------------------------------------------------
module dtcm_lsu #(
    parameter int DP = 256,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    dtcm_lsu_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    state_e        state_q;

    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic [4:0]    rsp_rd_q;
    logic          rsp_err_q;

    // Load context captured at accept, consumed in RD_WAIT.
    logic [1:0]    ld_off_q;
    logic [1:0]    ld_size_q;
    logic          ld_uns_q;
    logic [4:0]    ld_rd_q;

    logic          accept;
    logic          req_err;
    logic          issue;
    logic [AW-1:0] word_idx;
    logic [DW-1:0] lane;
    logic [DW-1:0] ld_data;

    assign bus.lsu_req_ready = (state_q == IDLE);
    assign accept            = bus.lsu_req_valid & bus.lsu_req_ready;

    assign word_idx = {2'b00, bus.lsu_req_addr[AW-1:2]};

    assign req_err = (bus.lsu_req_size == 2'b11)
                   | ((bus.lsu_req_size == 2'b01) & bus.lsu_req_addr[0])
                   | ((bus.lsu_req_size == 2'b10) & (|bus.lsu_req_addr[1:0]))
                   | (word_idx >= AW'(DP));

    // Only error-free accepted requests ever reach the DTCM.
    assign issue = accept & ~req_err;

    always_comb begin
        bus.mem_cs   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_bwen = 4'b0000;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        if (issue) begin
            bus.mem_cs   = 1'b1;
            bus.mem_wr   = bus.lsu_req_wr;
            bus.mem_addr = word_idx;
            if (bus.lsu_req_wr) begin
                case (bus.lsu_req_size)
                    2'b00: begin
                        bus.mem_bwen = 4'b0001 << bus.lsu_req_addr[1:0];
                        bus.mem_data = {4{bus.lsu_req_wdata[7:0]}};
                    end
                    2'b01: begin
                        bus.mem_bwen = bus.lsu_req_addr[1] ? 4'b1100 : 4'b0011;
                        bus.mem_data = {2{bus.lsu_req_wdata[15:0]}};
                    end
                    default: begin
                        bus.mem_bwen = 4'b1111;
                        bus.mem_data = bus.lsu_req_wdata;
                    end
                endcase
            end
        end
    end

    // Lane extraction: shift the addressed byte/half down to bit 0, then
    // extend. Word loads are aligned, so the shift is zero for them.
    always_comb begin
        lane    = bus.mem_data_wb >> {ld_off_q, 3'b000};
        ld_data = lane;
        case (ld_size_q)
            2'b00:   ld_data = {{24{~ld_uns_q & lane[7]}},  lane[7:0]};
            2'b01:   ld_data = {{16{~ld_uns_q & lane[15]}}, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

    // Stores and errors answer from IDLE at T+1; loads answer from RD_WAIT
    // at T+2. ready is low in RD_WAIT, so the two paths never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
            ld_off_q    <= '0;
            ld_size_q   <= '0;
            ld_uns_q    <= 1'b0;
            ld_rd_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_err | bus.lsu_req_wr) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_rd_q    <= bus.lsu_req_rd;
                            rsp_err_q   <= req_err;
                        end else begin
                            state_q   <= RD_WAIT;
                            ld_off_q  <= bus.lsu_req_addr[1:0];
                            ld_size_q <= bus.lsu_req_size;
                            ld_uns_q  <= bus.lsu_req_unsigned;
                            ld_rd_q   <= bus.lsu_req_rd;
                        end
                    end
                end
                RD_WAIT: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= ld_data;
                    rsp_rd_q    <= ld_rd_q;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.lsu_rsp_valid = rsp_valid_q;
    assign bus.lsu_rsp_rdata = rsp_rdata_q;
    assign bus.lsu_rsp_rd    = rsp_rd_q;
    assign bus.lsu_rsp_err   = rsp_err_q;

endmodule
